// File: rtl/cnt_pkg.sv
// Shared op codes and FSM state encoding for the counter command sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package cnt_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/cnt_step_timer.sv
// Loadable down-counter that paces a COUNT run one step per cycle.
// Latency: start loads the step count on the next edge; strobe/last are combinational from it.
// Backpressure: none; stop clears the count immediately on the next edge.
module cnt_step_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] steps,
    input  logic          stop,
    output logic          strobe,
    output logic          last
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] rem;

    // Remaining-step register: load on start, clear on stop, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem <= '0;
        end else if (start) begin
            rem <= steps;
        end else if (stop) begin
            rem <= '0;
        end else if (rem != '0) begin
            rem <= rem - ONE;
        end
    end

    // A step is in progress whenever steps remain; the final step is the one at rem==1.
    always_comb begin
        strobe = (rem != '0);
        last   = (rem == ONE);
    end

endmodule

// File: rtl/cnt_cmd_ctrl.sv
// Command sequencer driving load/step strobes into an up/down load counter.
// Latency: strobes start the cycle after accept; done one cycle after the last strobe/load.
// Backpressure: cmd_ready only in IDLE; commands presented while busy stay unconsumed.
module cnt_cmd_ctrl
    import cnt_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_steps,
    input  logic          abort,
    output logic          en_load,
    output logic [N-1:0]  load,
    output logic          up_down,
    output logic          cnt_en,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    state_e        state;
    state_e        nxt;
    logic          accept;
    logic          has_steps;
    logic          start_run;
    logic          abort_hit;
    logic          tm_strobe;
    logic          tm_last;

    logic          en_load_d;
    logic [N-1:0]  load_d;
    logic          up_down_d;
    logic          cnt_en_d;
    logic          busy_d;
    logic          done_d;
    logic          aborted_d;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign has_steps = |cmd_steps;
    assign start_run = accept & cmd_op[1] & has_steps;
    // An abort landing on the final step loses: that step still counts.
    assign abort_hit = (state == S_RUN) & tm_strobe & abort & ~tm_last;

    cnt_step_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (start_run),
        .steps  (cmd_steps),
        .stop   (abort_hit),
        .strobe (tm_strobe),
        .last   (tm_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_LOAD:       nxt = S_LOAD;
                        OP_UP, OP_DOWN: nxt = has_steps ? S_RUN : S_DONE;
                        default:       nxt = S_DONE;
                    endcase
                end
            end
            S_LOAD:  nxt = S_DONE;
            S_RUN:   nxt = (tm_last || abort_hit) ? S_DONE : S_RUN;
            default: nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every strobe lines up with its state cycle-exactly.
    always_comb begin
        en_load_d = (nxt == S_LOAD);
        cnt_en_d  = (nxt == S_RUN);
        busy_d    = (nxt != S_IDLE);
        done_d    = (nxt == S_DONE);
        load_d    = (accept && cmd_op == OP_LOAD) ? cmd_data : load;
        up_down_d = start_run ? ~cmd_op[0] : up_down;
        if (accept) begin
            aborted_d = 1'b0;
        end else if (abort_hit) begin
            aborted_d = 1'b1;
        end else begin
            aborted_d = aborted;
        end
    end

    // Output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_load <= 1'b0;
            load    <= '0;
            up_down <= 1'b0;
            cnt_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            en_load <= en_load_d;
            load    <= load_d;
            up_down <= up_down_d;
            cnt_en  <= cnt_en_d;
            busy    <= busy_d;
            done    <= done_d;
            aborted <= aborted_d;
        end
    end

endmodule

// File: tb/tb_cnt_cmd_ctrl.sv
// Directed bench for cnt_cmd_ctrl with a chained up/down counter model.
// Latency: per-cycle capture of outputs after each accepted command.
// Backpressure: exercises held cmd_valid while busy.
module tb_cnt_cmd_ctrl;

    localparam int N  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [N-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_steps = '0;
    logic          abort = 1'b0;
    logic          en_load;
    logic [N-1:0]  load;
    logic          up_down;
    logic          cnt_en;
    logic          busy;
    logic          done;
    logic          aborted;

    int errors = 0;
    int checks = 0;

    logic [7:0]  model_cnt = 8'h00;
    logic [15:0] p_en_load, p_cnt_en, p_done, p_ready, p_busy, p_aborted, p_overlap;
    logic [7:0]  load_c1;

    cnt_cmd_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .en_load   (en_load),
        .load      (load),
        .up_down   (up_down),
        .cnt_en    (cnt_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    // Downstream counter fed by the controller's strobes.
    always @(posedge clk) begin
        if (en_load)     model_cnt <= load;
        else if (cnt_en) model_cnt <= up_down ? model_cnt + 8'd1 : model_cnt - 8'd1;
    end

    // Present one command from IDLE, then capture outputs for cycles T+1..T+ncyc.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                           input logic [7:0] steps, input int ncyc, input int abort_cyc);
        p_en_load = '0; p_cnt_en = '0; p_done = '0; p_ready = '0;
        p_busy = '0; p_aborted = '0; p_overlap = '0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            p_en_load[c-1] = en_load;
            p_cnt_en[c-1]  = cnt_en;
            p_done[c-1]    = done;
            p_ready[c-1]   = cmd_ready;
            p_busy[c-1]    = busy;
            p_aborted[c-1] = aborted;
            p_overlap[c-1] = en_load & cnt_en;
            if (c == 1) load_c1 = load;
            abort = (c == abort_cyc);
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, en_load, cnt_en, busy, done, aborted, up_down} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outs: got %b exp %b",
                     {cmd_ready, en_load, cnt_en, busy, done, aborted, up_down}, 7'b1000000);
        end
        checks++;
        if (load !== 8'h00) begin
            errors++;
            $display("FAIL reset_load: got %h exp %h", load, 8'h00);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got %b exp %b", {cmd_ready, busy, done}, 3'b100);
        end
    endtask

    task automatic test_load();
        run_cmd(2'b01, 8'hA5, 8'd0, 3, 0);
        checks++;
        if (p_en_load[2:0] !== 3'b001) begin
            errors++; $display("FAIL load_en_load: got %b exp %b", p_en_load[2:0], 3'b001);
        end
        checks++;
        if (load_c1 !== 8'hA5) begin
            errors++; $display("FAIL load_value: got %h exp %h", load_c1, 8'hA5);
        end
        checks++;
        if (p_done[2:0] !== 3'b010) begin
            errors++; $display("FAIL load_done: got %b exp %b", p_done[2:0], 3'b010);
        end
        checks++;
        if ({p_ready[2:0], p_busy[2:0]} !== 6'b100_011) begin
            errors++; $display("FAIL load_ready_busy: got %b exp %b", {p_ready[2:0], p_busy[2:0]}, 6'b100011);
        end
        checks++;
        if (model_cnt !== 8'hA5) begin
            errors++; $display("FAIL load_counter: got %h exp %h", model_cnt, 8'hA5);
        end
    endtask

    task automatic test_count_up();
        run_cmd(2'b10, 8'h00, 8'd5, 7, 0);
        checks++;
        if (p_cnt_en[6:0] !== 7'b0011111) begin
            errors++; $display("FAIL up_cnt_en: got %b exp %b", p_cnt_en[6:0], 7'b0011111);
        end
        checks++;
        if (p_done[6:0] !== 7'b0100000) begin
            errors++; $display("FAIL up_done: got %b exp %b", p_done[6:0], 7'b0100000);
        end
        checks++;
        if ({p_en_load[6:0], p_overlap[6:0]} !== 14'd0) begin
            errors++; $display("FAIL up_no_load: got %b exp %b", {p_en_load[6:0], p_overlap[6:0]}, 14'd0);
        end
        checks++;
        if (up_down !== 1'b1) begin
            errors++; $display("FAIL up_dir: got %b exp %b", up_down, 1'b1);
        end
        checks++;
        if (model_cnt !== 8'hAA) begin
            errors++; $display("FAIL up_counter: got %h exp %h", model_cnt, 8'hAA);
        end
    endtask

    task automatic test_zero_steps();
        run_cmd(2'b11, 8'h00, 8'd0, 2, 0);
        checks++;
        if ({p_cnt_en[1:0], p_done[1:0], p_ready[1:0]} !== 6'b00_01_10) begin
            errors++;
            $display("FAIL zero_steps: got %b exp %b", {p_cnt_en[1:0], p_done[1:0], p_ready[1:0]}, 6'b000110);
        end
        checks++;
        if (up_down !== 1'b1) begin
            errors++; $display("FAIL zero_steps_dir: got %b exp %b", up_down, 1'b1);
        end
    endtask

    task automatic test_abort();
        run_cmd(2'b11, 8'h00, 8'd10, 6, 4);
        checks++;
        if (p_cnt_en[5:0] !== 6'b001111) begin
            errors++; $display("FAIL abort_cnt_en: got %b exp %b", p_cnt_en[5:0], 6'b001111);
        end
        checks++;
        if (p_done[5:0] !== 6'b010000) begin
            errors++; $display("FAIL abort_done: got %b exp %b", p_done[5:0], 6'b010000);
        end
        checks++;
        if ({p_aborted[5:0], aborted} !== 7'b1100001) begin
            errors++; $display("FAIL abort_flag: got %b exp %b", {p_aborted[5:0], aborted}, 7'b1100001);
        end
        checks++;
        if ({up_down, model_cnt} !== {1'b0, 8'hA6}) begin
            errors++; $display("FAIL abort_counter: got %h exp %h", {up_down, model_cnt}, {1'b0, 8'hA6});
        end
        run_cmd(2'b00, 8'h00, 8'd0, 2, 0);
        checks++;
        if ({p_aborted[1:0], p_done[1:0]} !== 4'b0001) begin
            errors++; $display("FAIL abort_clear: got %b exp %b", {p_aborted[1:0], p_done[1:0]}, 4'b0001);
        end
    endtask

    task automatic test_abort_last_and_idle();
        run_cmd(2'b10, 8'h00, 8'd2, 4, 2);
        checks++;
        if ({p_cnt_en[3:0], p_done[3:0], p_aborted[3:0]} !== 12'b0011_0100_0000) begin
            errors++;
            $display("FAIL abort_last: got %b exp %b", {p_cnt_en[3:0], p_done[3:0], p_aborted[3:0]}, 12'b001101000000);
        end
        checks++;
        if ({up_down, model_cnt} !== {1'b1, 8'hA8}) begin
            errors++; $display("FAIL abort_last_counter: got %h exp %h", {up_down, model_cnt}, {1'b1, 8'hA8});
        end
        run_cmd(2'b00, 8'h00, 8'd0, 2, 1);
        checks++;
        if ({p_aborted[1:0], aborted, p_done[1:0]} !== 5'b00001) begin
            errors++; $display("FAIL abort_outside_run: got %b exp %b", {p_aborted[1:0], aborted, p_done[1:0]}, 5'b00001);
        end
    endtask

    task automatic test_reset_mid_run();
        logic busy_ok;
        busy_ok = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_steps = 8'd20;
        @(posedge clk); #1;
        cmd_op = 2'b01; cmd_data = 8'h3C;
        for (int c = 1; c <= 3; c++) begin
            if (cmd_ready !== 1'b0 || en_load !== 1'b0 || cnt_en !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++; $display("FAIL busy_hold: got %b exp %b", busy_ok, 1'b1);
        end
        checks++;
        if (load !== 8'hA5) begin
            errors++; $display("FAIL busy_not_consumed: got %h exp %h", load, 8'hA5);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cnt_en, busy, en_load, done, aborted} !== 5'b00000) begin
            errors++; $display("FAIL async_reset: got %b exp %b", {cnt_en, busy, en_load, done, aborted}, 5'b00000);
        end
        cmd_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, busy, done, aborted, cnt_en} !== 5'b10000) begin
            errors++; $display("FAIL post_reset: got %b exp %b", {cmd_ready, busy, done, aborted, cnt_en}, 5'b10000);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_count_up();
        test_zero_steps();
        test_abort();
        test_abort_last_and_idle();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
